// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM state enum, the requester port-ID enum and the legal
// read-latency bounds, plus the width of the latency counter.
package dmem_arb_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_id_t;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;

  // Wide enough to hold RD_LAT_MAX.
  localparam int unsigned LAT_CNT_W = 3;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-input winner selection for the data-memory arbiter.
// Build option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin on ties
// (the port not granted last wins); otherwise CPU has fixed priority.
// Ports:
//   cpu_req, dbg_req  in   pending requests
//   last_win          in   previous winner (round-robin build only)
//   any_req_c         out  at least one request pending
//   win_c             out  selected port (valid when any_req_c)
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic     cpu_req,
  input  logic     dbg_req,
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  input  port_id_t last_win,
`endif
  output logic     any_req_c,
  output port_id_t win_c
);

  // Tie handling is the only thing the build option changes.
  always_comb begin
    any_req_c = cpu_req | dbg_req;
    win_c     = PORT_CPU;
    if (cpu_req && dbg_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      win_c = (last_win == PORT_CPU) ? PORT_DBG : PORT_CPU;
`else
      win_c = PORT_CPU;
`endif
    end else if (dbg_req) begin
      win_c = PORT_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug loader) arbiter in front of a single data memory.
// Grants are combinational in the request cycle; writes finish in the
// grant cycle, reads wait RD_LAT cycles and return data to the owner.
// Build option: DMEM_ARB_ROUND_ROBIN_EN (round-robin ties, else CPU wins).
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   cpu_*/dbg_* req,we,addr,wdata,wstrb  requester commands
//   cpu_*/dbg_* gnt,rvalid,rdata         requester responses
//   mem_en,mem_we,mem_addr,mem_wdata,mem_wstrb  memory command
//   mem_rdata                   memory read data, RD_LAT after mem_en
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  output logic                cpu_gnt,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  input  logic [DATA_W/8-1:0] dbg_wstrb,
  output logic                dbg_gnt,
  output logic                dbg_rvalid,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  arb_state_t           state, state_nxt;
  logic [LAT_CNT_W-1:0] cnt, cnt_nxt;
  port_id_t             owner, owner_nxt;
  logic [DATA_W-1:0]    cpu_rdata_q, dbg_rdata_q;
  logic                 any_req_c;
  port_id_t             win_c;
  logic                 done_c;
  logic                 open_c;
  logic                 grant_c;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  port_id_t             last_win;
`endif

  dmem_arb_pick u_pick (
    .cpu_req   (cpu_req),
    .dbg_req   (dbg_req),
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    .last_win  (last_win),
`endif
    .any_req_c (any_req_c),
    .win_c     (win_c)
  );

  // Read data is forwarded in the rvalid cycle and held afterwards.
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rdata_q;

  // Next state, grant and memory command. The last RD_WAIT cycle doubles
  // as an IDLE slot so back-to-back reads sustain one per RD_LAT cycles.
  // Everything is gated by rst so a reset cycle issues nothing.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    owner_nxt  = owner;
    cpu_gnt    = 1'b0;
    dbg_gnt    = 1'b0;
    cpu_rvalid = 1'b0;
    dbg_rvalid = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;

    done_c  = rst && (state == ST_RD_WAIT) && (cnt == LAT_CNT_W'(1));
    open_c  = rst && ((state == ST_IDLE) || done_c);
    grant_c = open_c && any_req_c;

    if (done_c) begin
      cpu_rvalid = (owner == PORT_CPU);
      dbg_rvalid = (owner == PORT_DBG);
      state_nxt  = ST_IDLE;
      cnt_nxt    = '0;
    end else if (state == ST_RD_WAIT) begin
      cnt_nxt = cnt - LAT_CNT_W'(1);
    end

    if (grant_c) begin
      mem_en = 1'b1;
      if (win_c == PORT_CPU) begin
        cpu_gnt   = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wstrb = cpu_wstrb;
      end else begin
        dbg_gnt   = 1'b1;
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        mem_wstrb = dbg_wstrb;
      end
      if (!mem_we) begin
        state_nxt = ST_RD_WAIT;
        cnt_nxt   = LAT_CNT_W'(RD_LAT);
        owner_nxt = win_c;
      end
    end
  end

  // State, counter, owner and held read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      owner       <= PORT_CPU;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      owner <= owner_nxt;
      if (cpu_rvalid) begin
        cpu_rdata_q <= mem_rdata;
      end
      if (dbg_rvalid) begin
        dbg_rdata_q <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Last winner; reset to dbg so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_win <= PORT_DBG;
    end else if (grant_c) begin
      last_win <= win_c;
    end
  end
`endif

  // STRB_W documents the strobe width relation used in the port list.
  logic unused_strb_w;
  assign unused_strb_w = (STRB_W == DATA_W / 8);

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of both requester ports and the memory port.
REQ-002 Parameter DATA_W, default 32, data width; strobe width is DATA_W/8.
REQ-003 Parameter RD_LAT, default 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..4.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 cpu_req / dbg_req  in  1  access request from the CPU load/store port / the debug-loader port.
REQ-007 cpu_we / dbg_we  in  1  1 = write, 0 = read.
REQ-008 cpu_addr / dbg_addr  in  ADDR_W  byte address.
REQ-009 cpu_wdata / dbg_wdata  in  DATA_W  write data.
REQ-010 cpu_wstrb / dbg_wstrb  in  DATA_W/8  byte enables for writes.
REQ-011 cpu_gnt / dbg_gnt  out  1  request accepted this cycle.
REQ-012 cpu_rvalid / dbg_rvalid  out  1  one-cycle pulse: read data valid.
REQ-013 cpu_rdata / dbg_rdata  out  DATA_W  read data, meaningful only with rvalid.
REQ-014 mem_en, mem_we  out  1  memory access strobe, write select.
REQ-015 mem_addr / mem_wdata / mem_wstrb  out  ADDR_W / DATA_W / DATA_W/8  memory command.
REQ-016 mem_rdata  in  DATA_W  memory read data.

Function
REQ-017 FSM states IDLE and RD_WAIT; the block SHALL accept a new request only in IDLE.
REQ-018 In IDLE with at least one req, the winner SHALL get gnt in the same cycle, with mem_en=1 and the winner's we/addr/wdata/wstrb driven to the mem_* outputs combinationally.
REQ-019 The loser's gnt SHALL be 0; a requester SHALL hold req and command stable until gnt, and the arbiter SHALL never drop a held request.
REQ-020 A granted write SHALL complete in the grant cycle; FSM stays IDLE; no rvalid is produced.
REQ-021 A granted read SHALL move the FSM to RD_WAIT, load a latency counter with RD_LAT, and record the owner.
REQ-022 In RD_WAIT the counter SHALL decrement each cycle, and mem_en and both gnt SHALL be 0.
REQ-023 RD_LAT cycles after the grant, the owner's rvalid SHALL pulse for one cycle with rdata=mem_rdata, and the FSM SHALL return to IDLE in that same cycle so a new grant can issue concurrently.
REQ-024 Read throughput SHALL be one read per RD_LAT cycles; write throughput SHALL be one per cycle.
REQ-025 Non-owner rvalid SHALL stay 0; each rdata output SHALL hold its last captured value.
REQ-026 With no req in IDLE, all mem_* strobes and all gnt SHALL be 0.

Reset
REQ-027 While rst=0 at a clock edge: FSM to IDLE, counter 0, owner cleared, last-winner register set to dbg (so CPU wins the first tie), all gnt and rvalid 0, both rdata 0.
REQ-028 Reset during RD_WAIT SHALL abandon the read with no rvalid pulse; mem_rdata arriving afterward SHALL be ignored.

Configuration
REQ-029 Macro DMEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests the port not granted last SHALL win; the last-winner register updates on every grant.
REQ-030 Macro undefined: fixed priority, CPU always wins ties; the last-winner register SHALL not be built.

Structure
REQ-031 Shared package dmem_arb_pkg SHALL hold the FSM state enum, the port-ID enum (PORT_CPU, PORT_DBG), and RD_LAT bounds.
REQ-032 One sub-module, dmem_arb_pick, SHALL hold the two-input priority/round-robin selection; FSM, counter and data return stay in dmem_arbiter.

Verification
REQ-033 RD_LAT=2: cpu read addr 0x10 (memory holds 0xDEADBEEF) -> cpu_gnt at cycle 0, cpu_rvalid with 0xDEADBEEF at cycle 2, dbg outputs quiet.
REQ-034 Simultaneous cpu write 0x20=0x11 and dbg write 0x24=0x22 -> CPU granted cycle 0, dbg cycle 1 (RR and fixed); memory holds both values.
REQ-035 RR build, both ports issue back-to-back reads continuously -> grants alternate CPU, DBG, CPU...; fixed build -> dbg_gnt never asserts while cpu_req is held.
REQ-036 dbg_req raised during a CPU RD_WAIT -> dbg_gnt 0 until the cpu_rvalid cycle, asserted in that same cycle.
REQ-037 rst=0 for one cycle mid RD_WAIT -> no rvalid pulse; next request is granted in IDLE normally.
REQ-038 Write with wstrb=4'b0010 over 0xFFFFFFFF, data 0x0000AB00 -> memory reads back 0xFFFFABFF.
